// File: rtl/audio_frame_sequencer.sv
// Frame sequencer for one audio processor instance: loads WORDS input words,
// pulses start, waits for the processor to finish, then streams the results out.
module audio_frame_sequencer #(
    parameter int unsigned INPUT_SIZE    = 512,
    parameter int unsigned WORDS         = 64,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned START_TIMEOUT = 8,
    localparam int unsigned IW           = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INPUT_SIZE-1:0] out_data,
    output logic                  ap_data_wr_en,
    output logic [IW-1:0]         ap_input_index,
    output logic [INPUT_SIZE-1:0] ap_data_in,
    output logic                  ap_start,
    input  logic                  ap_done,
    output logic [IW-1:0]         ap_output_index,
    input  logic [INPUT_SIZE-1:0] ap_data_out,
    output logic                  busy,
    output logic [15:0]           frames_done,
    output logic                  err_start
);

    localparam int unsigned LW = $clog2(RD_LATENCY + 1) + 1;
    localparam int unsigned TW = $clog2(START_TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StWaitBusy, StWaitDone, StReadWait, StReadHold
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           wr_cnt_q, wr_cnt_d;
    logic [IW-1:0]           rd_cnt_q, rd_cnt_d;
    logic [LW-1:0]           lat_cnt_q, lat_cnt_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [INPUT_SIZE-1:0]   out_data_q, out_data_d;
    logic [15:0]             frames_q, frames_d;
    logic                    err_start_q, err_start_d;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            lat_cnt_q   <= '0;
            to_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            frames_q    <= '0;
            err_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            to_cnt_q    <= to_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            frames_q    <= frames_d;
            err_start_q <= err_start_d;
        end
    end

    // Next-state and counter update logic
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        to_cnt_d    = to_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        frames_d    = frames_q;
        err_start_d = err_start_q;
        unique case (state_q)
            // Wait for a processor that may still be mid-frame from before our reset
            StIdle: begin
                if (ap_done) state_d = StLoad;
            end
            StLoad: begin
                if (in_valid) begin
                    if (wr_cnt_q == IW'(WORDS - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = StStart;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                to_cnt_d = '0;
                state_d  = StWaitBusy;
            end
            StWaitBusy: begin
                if (!ap_done) begin
                    state_d = StWaitDone;
                end else if (to_cnt_q == TW'(START_TIMEOUT - 1)) begin
                    // Processor never acknowledged the start: flag it and retry
                    err_start_d = 1'b1;
                    state_d     = StStart;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (ap_done) begin
                    rd_cnt_d  = '0;
                    lat_cnt_d = '0;
                    state_d   = StReadWait;
                end
            end
            StReadWait: begin
                if (lat_cnt_q == LW'(RD_LATENCY)) begin
                    out_data_d  = ap_data_out;
                    out_valid_d = 1'b1;
                    state_d     = StReadHold;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            StReadHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    lat_cnt_d   = '0;
                    if (rd_cnt_q == IW'(WORDS - 1)) begin
                        rd_cnt_d = '0;
                        frames_d = frames_q + 16'd1;
                        state_d  = StLoad;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        state_d  = StReadWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Combinational outputs decoded from the current state
    always_comb begin
        in_ready       = 1'b0;
        ap_data_wr_en  = 1'b0;
        ap_input_index = '0;
        ap_data_in     = '0;
        ap_start       = 1'b0;
        busy           = 1'b1;
        unique case (state_q)
            StIdle: busy = 1'b0;
            StLoad: begin
                busy           = 1'b0;
                in_ready       = 1'b1;
                ap_data_wr_en  = in_valid;
                ap_input_index = wr_cnt_q;
                ap_data_in     = in_data;
            end
            StStart: ap_start = 1'b1;
            default: ;
        endcase
    end

    assign ap_output_index = rd_cnt_q;
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign frames_done     = frames_q;
    assign err_start       = err_start_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench for audio_frame_sequencer with a small behavioural processor model.
module tb_audio_frame_sequencer;

    localparam int W     = 512;
    localparam int WORDS = 64;
    localparam int IW    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          ap_data_wr_en;
    logic [IW-1:0] ap_input_index;
    logic [W-1:0]  ap_data_in;
    logic          ap_start;
    logic          ap_done;
    logic [IW-1:0] ap_output_index;
    logic [W-1:0]  ap_data_out;
    logic          busy;
    logic [15:0]   frames_done;
    logic          err_start;

    always #5 clk = ~clk;

    audio_frame_sequencer #(
        .INPUT_SIZE(W),
        .WORDS(WORDS),
        .RD_LATENCY(1),
        .START_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .ap_data_wr_en(ap_data_wr_en),
        .ap_input_index(ap_input_index),
        .ap_data_in(ap_data_in),
        .ap_start(ap_start),
        .ap_done(ap_done),
        .ap_output_index(ap_output_index),
        .ap_data_out(ap_data_out),
        .busy(busy),
        .frames_done(frames_done),
        .err_start(err_start)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [W-1:0] gen(input int f, input int i);
        logic [W-1:0] w;
        for (int k = 0; k < 16; k++)
            w[k*32 +: 32] = (32'(f) * 32'h0100_0193) ^ (32'(i) * 32'h0000_9E37)
                            ^ (32'(k) << 20) ^ 32'h1357_0000;
        return w;
    endfunction

    function automatic logic [W-1:0] mask(input logic [IW-1:0] i);
        return {16{26'h2A5A5A5, i}};
    endfunction

    function automatic logic [W-1:0] expect_out(input int f, input int i);
        return gen(f, i) ^ mask(IW'(i));
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Processor model: input/output buffer plus a start/busy/done handshake
    logic [W-1:0] pmem [WORDS];
    logic p_done   = 1'b1;
    int   p_phase  = 0;
    int   p_cnt    = 0;
    logic ign_used = 1'b0;
    logic ignore_next;
    logic hold_low;
    int   busy_len;

    assign ap_done = p_done & ~hold_low;

    always @(posedge clk) begin
        if (ap_data_wr_en) pmem[ap_input_index] <= ap_data_in;
        ap_data_out <= pmem[ap_output_index] ^ mask(ap_output_index);
        if (p_phase == 1) begin
            if (p_cnt <= 1) begin
                p_done  <= 1'b0;
                p_phase <= 2;
                p_cnt   <= busy_len;
            end else p_cnt <= p_cnt - 1;
        end else if (p_phase == 2) begin
            if (p_cnt <= 1) begin
                p_done  <= 1'b1;
                p_phase <= 0;
            end else p_cnt <= p_cnt - 1;
        end else if (ap_start) begin
            if (ignore_next && !ign_used) ign_used <= 1'b1;
            else begin
                p_phase <= 1;
                p_cnt   <= 2;
            end
        end
    end

    // Observers: collected output words, handshake gaps, write/start activity
    logic [W-1:0]  outq [$];
    int            gapq [$];
    int            cyc = 0;
    int            last_hs = 0;
    int            wr_pulses = 0;
    int            wr_bad = 0;
    int            start_pulses = 0;
    logic [IW-1:0] mon_idx = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && out_valid && out_ready) begin
            outq.push_back(out_data);
            gapq.push_back(cyc - last_hs);
            last_hs <= cyc;
        end
        if (rst_n && ap_data_wr_en) begin
            if (ap_input_index != mon_idx) wr_bad <= wr_bad + 1;
            mon_idx   <= mon_idx + 1'b1;
            wr_pulses <= wr_pulses + 1;
        end
        if (rst_n && ap_start) start_pulses <= start_pulses + 1;
    end

    task automatic load_frame(input int f, input int stall_after);
        int   i = 0;
        int   guard = 0;
        int   stall_bad = 0;
        logic hs;
        while (i < WORDS && guard < 2000) begin
            in_valid = 1'b1;
            in_data  = gen(f, i);
            hs       = in_ready;
            tick();
            guard++;
            if (hs) begin
                i++;
                if (i == stall_after + 1) begin
                    in_valid = 1'b0;
                    repeat (10) begin
                        tick();
                        if (ap_data_wr_en !== 1'b0 || ap_input_index !== IW'(i)) stall_bad++;
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        check($sformatf("load_words_f%0d", f), i, WORDS);
        if (stall_after >= 0) check("stall_hold", stall_bad, 0);
    endtask

    task automatic read_frame(input int f, input int base, input int bp_word, input int gaps);
        int          guard = 0;
        int          bp_bad = 0;
        int          data_bad = 0;
        int          gap_bad = 0;
        logic        bp_done = 1'b0;
        logic [15:0] fd0;
        logic [W-1:0] held;
        fd0 = frames_done;
        out_ready = 1'b1;
        while (frames_done == fd0 && guard < 3000) begin
            if (bp_word >= 0 && !bp_done && out_valid && ap_output_index == IW'(bp_word)) begin
                held      = out_data;
                out_ready = 1'b0;
                repeat (7) begin
                    tick();
                    if (out_valid !== 1'b1 || out_data !== held ||
                        ap_output_index !== IW'(bp_word)) bp_bad++;
                end
                out_ready = 1'b1;
                bp_done   = 1'b1;
                check("backpressure_hold", bp_bad, 0);
                check("backpressure_word", held, expect_out(f, bp_word));
            end
            tick();
            guard++;
        end
        check($sformatf("frame_end_f%0d", f), guard < 3000, 1'b1);
        check($sformatf("out_count_f%0d", f), outq.size() - base, WORDS);
        for (int i = 0; i < WORDS; i++) begin
            if (base + i >= outq.size() || outq[base + i] !== expect_out(f, i)) data_bad++;
            if (gaps != 0 && i > 0 && base + i < gapq.size() && gapq[base + i] != 3) gap_bad++;
        end
        check($sformatf("out_data_f%0d", f), data_bad, 0);
        if (gaps != 0) check("read_throughput", gap_bad, 0);
        check($sformatf("back_in_load_f%0d", f), {in_ready, busy}, 2'b10);
    endtask

    initial begin
        int base;
        int wp0;
        int sp0;
        int t;
        int n;
        int idle_bad;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        hold_low    = 1'b0;
        ignore_next = 1'b0;
        busy_len    = 500;

        repeat (3) tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_frames_done", frames_done, 16'd0);
        check("rst_err_start", err_start, 1'b0);
        check("rst_ap_start", ap_start, 1'b0);
        check("rst_wr_en", ap_data_wr_en, 1'b0);
        check("rst_out_index", ap_output_index, '0);

        rst_n = 1'b1;
        tick();
        check("idle_to_load", {in_ready, busy, ap_input_index}, {1'b1, 1'b0, 6'd0});

        // Frame 1: continuous streams, long processor busy time
        base = outq.size();
        wp0  = wr_pulses;
        sp0  = start_pulses;
        load_frame(1, -1);
        read_frame(1, base, -1, 1);
        check("f1_wr_pulses", wr_pulses - wp0, WORDS);
        check("f1_start_pulses", start_pulses - sp0, 1);
        check("f1_frames_done", frames_done, 16'd1);
        check("f1_err_start", err_start, 1'b0);

        // Frame 2: input stall after word 17, output backpressure on word 5
        busy_len = 20;
        base = outq.size();
        load_frame(2, 17);
        read_frame(2, base, 5, 0);
        check("f2_frames_done", frames_done, 16'd2);

        // Frame 3: processor ignores the first start pulse
        ignore_next = 1'b1;
        base = outq.size();
        sp0  = start_pulses;
        load_frame(3, -1);
        t = 0;
        while (!ap_start && t < 20) begin
            tick();
            t++;
        end
        check("first_start_seen", ap_start, 1'b1);
        n = 0;
        while (!err_start && n < 20) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, 9);
        check("retry_start", ap_start, 1'b1);
        read_frame(3, base, -1, 0);
        check("err_start_sticky", err_start, 1'b1);
        check("f3_start_pulses", start_pulses - sp0, 2);

        // Frame 4: reset while word 30 is being presented
        base = outq.size();
        load_frame(4, -1);
        out_ready = 1'b1;
        t = 0;
        while (!(out_valid && ap_output_index == 6'd30) && t < 3000) begin
            tick();
            t++;
        end
        check("reached_word30", {out_valid, ap_output_index}, {1'b1, 6'd30});
        rst_n    = 1'b0;
        hold_low = 1'b1;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        check("midrst_busy", {busy, in_ready}, 2'b00);
        check("midrst_frames_done", frames_done, 16'd0);
        check("midrst_err_start", err_start, 1'b0);
        check("midrst_out_index", ap_output_index, '0);
        idle_bad = 0;
        repeat (20) begin
            tick();
            if (in_ready !== 1'b0 || busy !== 1'b0 || ap_data_wr_en !== 1'b0) idle_bad++;
        end
        check("idle_waits_done", idle_bad, 0);
        hold_low = 1'b0;
        tick();
        check("load_after_rst", {in_ready, ap_input_index}, {1'b1, 6'd0});

        // Frame 5: clean frame after the interrupted one
        base = outq.size();
        load_frame(5, -1);
        read_frame(5, base, -1, 0);
        check("f5_frames_done", frames_done, 16'd1);

        // Frame 6: counter wrap from 0xFFFF
        force dut.frames_q = 16'hFFFF;
        #1;
        release dut.frames_q;
        base = outq.size();
        load_frame(6, -1);
        read_frame(6, base, -1, 0);
        check("frames_done_wrap", frames_done, 16'd0);
        check("wr_index_order", wr_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/audio_frame_sequencer.md
Name: audio_frame_sequencer

Overview:
Host-side controller that sequences one audio processor instance frame by frame. It streams WORDS input words from a valid/ready source into the processor's input buffer and pulses start. It then waits for the processor to go busy and return to done. Finally it reads the WORDS result words back out through a valid/ready sink. It sits between the host DMA/FIFO logic and the processor, and replaces per-word software sequencing of the LDE/SYN/STE instructions.

Parameters:
INPUT_SIZE, 512, width of one data word in bits (one input/output buffer slot)
WORDS, 64, words per frame (2048 samples x 16 bits / 512)
RD_LATENCY, 1, cycles from ap_output_index change to valid ap_data_out (0 = combinational)
START_TIMEOUT, 8, max cycles to wait for ap_done to fall after ap_start
IW, $clog2(WORDS), index width (derived, localparam)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  host input word valid
in_ready  output  1  sequencer accepts input word
in_data  input  INPUT_SIZE  host input word
out_valid  output  1  result word valid
out_ready  input  1  host accepts result word
out_data  output  INPUT_SIZE  result word
ap_data_wr_en  output  1  processor input buffer write enable
ap_input_index  output  IW  processor input buffer slot
ap_data_in  output  INPUT_SIZE  processor input word (= in_data)
ap_start  output  1  processor start pulse
ap_done  input  1  processor idle/done flag
ap_output_index  output  IW  processor output buffer slot
ap_data_out  input  INPUT_SIZE  processor output word
busy  output  1  high in every state except IDLE and LOAD
frames_done  output  16  completed-frame counter, wraps 0xFFFF->0
err_start  output  1  sticky: processor failed to go busy within START_TIMEOUT

Behaviour:
- The clock is clk. Reset rst_n is synchronous and active-low: on a clk edge with rst_n=0, all state is cleared.
- Reset values: state=IDLE, wr_cnt=0, rd_cnt=0, lat_cnt=0, to_cnt=0, out_valid=0, out_data=0, frames_done=0, err_start=0. Combinational outputs are 0 in IDLE.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, READ_WAIT, READ_HOLD.
- IDLE:
  - Go to LOAD when ap_done=1.
  - This covers a processor still mid-frame after our reset: the sequencer waits for it.
- LOAD:
  - in_ready=1.
  - ap_data_wr_en = in_valid & in_ready, combinational. ap_input_index=wr_cnt. ap_data_in=in_data.
  - Each accepted word increments wr_cnt.
  - On accepting word WORDS-1: wr_cnt<=0, go to START.
  - No timeout; in_valid may stall indefinitely.
- START:
  - ap_start=1 for exactly one cycle. to_cnt<=0. Go to WAIT_BUSY.
- WAIT_BUSY:
  - If ap_done=0: go to WAIT_DONE.
  - Else to_cnt++.
  - If to_cnt==START_TIMEOUT-1 while ap_done is still 1: err_start<=1, go to START (retry).
- WAIT_DONE:
  - When ap_done=1: rd_cnt<=0, lat_cnt<=0, go to READ_WAIT.
  - No timeout.
- ap_output_index = rd_cnt in all states. It is held stable in READ_WAIT and READ_HOLD.
- READ_WAIT:
  - lat_cnt increments each cycle.
  - When lat_cnt==RD_LATENCY: out_data<=ap_data_out, out_valid<=1, go to READ_HOLD.
  - With RD_LATENCY=0, the capture happens in the first READ_WAIT cycle.
- READ_HOLD:
  - out_valid=1 and out_data are held until out_ready.
  - On out_valid & out_ready: out_valid<=0, lat_cnt<=0.
  - If rd_cnt==WORDS-1: rd_cnt<=0, frames_done++, go to LOAD.
  - Else rd_cnt++, go to READ_WAIT.
- Throughput: one result word per RD_LATENCY+2 cycles with out_ready tied high. Input accepts one word per cycle.
- in_ready is 0 outside LOAD. out_valid is 0 outside READ_HOLD.
- err_start is cleared only by reset.
- Reset asserted in any state (including mid-read with out_valid=1) takes effect on that edge. Partially read frames are discarded.

Test Plan:
- Full frame, RD_LATENCY=1, ready/valid always high; model processor drops ap_done 2 cycles after start and raises it 500 cycles later -> 64 ap_data_wr_en pulses at indices 0..63, one ap_start pulse, 64 out words matching model slots 0..63 in order, frames_done=1, back in LOAD.
- Input stalls: in_valid low for 10 cycles after word 17 -> no writes during the stall, wr_cnt holds at 18, word 18 is written to index 18 when valid returns.
- Output backpressure: out_ready low for 7 cycles on word 5 -> out_valid and out_data stable throughout, ap_output_index stays 5, no word skipped or duplicated.
- Start timeout, START_TIMEOUT=8: model ignores the first ap_start -> err_start=1 after 8 WAIT_BUSY cycles, a second ap_start pulse follows, the frame completes normally, and err_start stays 1.
- Reset mid-read at word 30, with ap_done held 0 for 20 cycles after reset -> outputs return to reset values and stay in IDLE until ap_done=1, then LOAD starts at index 0.
- frames_done preloaded via 65535 frames (or forced) -> the next frame completion wraps it to 0.
